// File: rtl/prog_fir_pkg.sv
// Shared defaults, FSM state type and status-word layout for the
// prog_fir coefficient loader.
package prog_fir_pkg;

  localparam int CHAN_W_DEF  = 8;
  localparam int NCHAN_DEF   = 256;
  localparam int TAP_W_DEF   = 4;
  localparam int COEFF_W_DEF = 16;
  localparam int RD_LAT_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } ld_state_e;

  localparam int ST_BUSY_BIT = 31;
  localparam int ST_ERR_BIT  = 30;
  localparam int ST_CNT_W    = 16;

endpackage

// File: rtl/prog_fir_coeff_loader_if.sv
// Staging-BRAM read port plus coefficient-RAM write port of the
// coefficient loader, seen from the loader (master) or memories (slave).
interface prog_fir_coeff_loader_if
  import prog_fir_pkg::*;
#(
  parameter int CHAN_W  = CHAN_W_DEF,
  parameter int TAP_W   = TAP_W_DEF,
  parameter int COEFF_W = COEFF_W_DEF
);

  logic [TAP_W-1:0]        stg_addr;
  logic [COEFF_W-1:0]      stg_data;
  logic                    cram_we;
  logic [CHAN_W+TAP_W-1:0] cram_addr;
  logic [COEFF_W-1:0]      cram_data;

  modport master (
    output stg_addr,
    input  stg_data,
    output cram_we,
    output cram_addr,
    output cram_data
  );

  modport slave (
    input  stg_addr,
    output stg_data,
    input  cram_we,
    input  cram_addr,
    input  cram_data
  );

endinterface

// File: rtl/prog_fir_rd_pipe.sv
// RD_LAT-deep delay line carrying the read-valid flag and tap index
// so they line up with the staging BRAM read data.
module prog_fir_rd_pipe #(
  parameter int RD_LAT = 2,
  parameter int TAP_W  = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             vld_i,
  input  logic [TAP_W-1:0] tap_i,
  output logic             vld_o,
  output logic [TAP_W-1:0] tap_o
);

  logic [RD_LAT-1:0] vld_q;
  logic [TAP_W-1:0]  tap_q [RD_LAT];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tap_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= vld_i;
      tap_q[0] <= tap_i;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tap_q[i] <= tap_q[i-1];
      end
    end
  end

  assign vld_o = vld_q[RD_LAT-1];
  assign tap_o = tap_q[RD_LAT-1];

endmodule

// File: rtl/prog_fir_coeff_loader.sv
// Copies NTAPS staged coefficients into one channel slot of the FIR
// coefficient RAM on each bit31 toggle. Option: FIR_LOAD_STATUS_EN.
module prog_fir_coeff_loader
  import prog_fir_pkg::*;
#(
  parameter int CHAN_W  = CHAN_W_DEF,
  parameter int NCHAN   = NCHAN_DEF,
  parameter int TAP_W   = TAP_W_DEF,
  parameter int COEFF_W = COEFF_W_DEF,
  parameter int RD_LAT  = RD_LAT_DEF
) (
  input  logic        user_clk,
  input  logic        user_rst,
  input  logic [31:0] load_chan_reg,
  prog_fir_coeff_loader_if.master mem,
  output logic        busy,
`ifdef FIR_LOAD_STATUS_EN
  output logic        load_err,
  output logic [31:0] load_status
`else
  output logic        load_err
`endif
);

  ld_state_e state_q;

  logic              tog_q;
  logic              tog_prev_q;
  logic [CHAN_W-1:0] chan_q;
  logic [TAP_W-1:0]  stg_addr_q;
  logic [TAP_W-1:0]  stg_addr_d;
  logic              busy_q;
  logic              err_q;

  logic                    cram_we_q;
  logic [CHAN_W+TAP_W-1:0] cram_addr_q;
  logic [COEFF_W-1:0]      cram_data_q;

  logic              cmd;
  logic [CHAN_W-1:0] chan_in;
  logic              chan_ok;
  logic              last_wr;
  logic              p_vld;
  logic [TAP_W-1:0]  p_tap;
  logic              unused_reg_bits;

  assign chan_in    = load_chan_reg[CHAN_W-1:0];
  assign chan_ok    = 32'(chan_in) < 32'(NCHAN);
  assign cmd        = tog_q ^ tog_prev_q;
  assign stg_addr_d = stg_addr_q + TAP_W'(1);
  assign last_wr    = cram_we_q && (cram_addr_q[TAP_W-1:0] == '1);

  assign unused_reg_bits = ^load_chan_reg[30:CHAN_W];

  prog_fir_rd_pipe #(
    .RD_LAT (RD_LAT),
    .TAP_W  (TAP_W)
  ) u_rd_pipe (
    .clk_i (user_clk),
    .rst_i (user_rst),
    .vld_i (state_q == READ),
    .tap_i (stg_addr_q),
    .vld_o (p_vld),
    .tap_o (p_tap)
  );

`ifdef FIR_LOAD_STATUS_EN
  logic [ST_CNT_W-1:0] load_cnt_q;
`endif

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q     <= IDLE;
      tog_q       <= 1'b0;
      tog_prev_q  <= 1'b0;
      chan_q      <= '0;
      stg_addr_q  <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      cram_we_q   <= 1'b0;
      cram_addr_q <= '0;
      cram_data_q <= '0;
`ifdef FIR_LOAD_STATUS_EN
      load_cnt_q  <= '0;
`endif
    end else begin
      tog_q      <= load_chan_reg[31];
      tog_prev_q <= tog_q;

      // Write stage: one register slice after the aligned read data.
      cram_we_q <= p_vld;
      if (p_vld) begin
        cram_addr_q <= {chan_q, p_tap};
        cram_data_q <= mem.stg_data;
      end

      unique case (state_q)
        IDLE: begin
          if (cmd) begin
            if (chan_ok) begin
              chan_q     <= chan_in;
              err_q      <= 1'b0;
              busy_q     <= 1'b1;
              stg_addr_q <= '0;
              state_q    <= READ;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        READ: begin
          if (cmd) err_q <= 1'b1;
          if (stg_addr_q == '1) begin
            stg_addr_q <= '0;
            state_q    <= DRAIN;
          end else begin
            stg_addr_q <= stg_addr_d;
          end
        end
        DRAIN: begin
          if (cmd) err_q <= 1'b1;
          if (last_wr) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
`ifdef FIR_LOAD_STATUS_EN
            load_cnt_q <= load_cnt_q + ST_CNT_W'(1);
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem.stg_addr  = stg_addr_q;
  assign mem.cram_we   = cram_we_q;
  assign mem.cram_addr = cram_addr_q;
  assign mem.cram_data = cram_data_q;
  assign busy          = busy_q;
  assign load_err      = err_q;

`ifdef FIR_LOAD_STATUS_EN
  always_comb begin
    load_status = '0;
    load_status[ST_BUSY_BIT] = busy_q;
    load_status[ST_ERR_BIT]  = err_q;
    load_status[ST_CNT_W-1:0] = load_cnt_q;
  end
`endif

endmodule
